// File: rtl/jtframe_sdm_dac_pkg.sv
// Shared helpers for the sigma-delta DAC: sample conversion, saturation and
// the mid-scale / feedback constants, all expressed as functions of W.
package jtframe_sdm_dac_pkg;

  // Internal arithmetic width; W <= 24 keeps W+4 signed headroom well inside.
  localparam int SDM_CALC_W = 32;

  // Mid-scale code, 2^(w-1)
  function automatic logic [SDM_CALC_W-1:0] sdm_mid(input int w);
    return 32'd1 << (w - 1);
  endfunction

  // Full-scale feedback step, 2^w
  function automatic logic [SDM_CALC_W-1:0] sdm_fb(input int w);
    return 32'd1 << w;
  endfunction

  // Two's complement -> offset binary when sgn is set; plain mask otherwise
  function automatic logic [SDM_CALC_W-1:0] sdm_offset_bin(
    input logic [SDM_CALC_W-1:0] s,
    input int                    w,
    input logic                  sgn
  );
    logic [SDM_CALC_W-1:0] mask;
    mask = sdm_fb(w) - 32'd1;
    return (s ^ (sgn ? sdm_mid(w) : 32'd0)) & mask;
  endfunction

  // Clamp v into the w-bit signed range [-2^(w-1), 2^(w-1)-1]
  function automatic logic signed [SDM_CALC_W-1:0] sdm_sat(
    input logic signed [SDM_CALC_W-1:0] v,
    input int                           w
  );
    logic signed [SDM_CALC_W-1:0] hi, lo;
    hi = $signed(sdm_mid(w)) - 32'sd1;
    lo = -$signed(sdm_mid(w));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/jtframe_sdm_ch.sv
// Single-channel sigma-delta modulator, first or second order.
// xe is an unsigned sample in [0, 2^W-1]; dout is the registered PDM bit.
module jtframe_sdm_ch
  import jtframe_sdm_dac_pkg::*;
#(
  parameter int W     = 16,
  parameter int ORDER = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic [W-1:0] xe,
  output logic         dout
);

  generate
    if (ORDER == 1) begin : g_o1
      logic [W-1:0] acc;
      logic [W:0]   sum;

      assign sum = {1'b0, acc} + {1'b0, xe};

      // Phase accumulator: the carry out is the output bit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc  <= '0;
          dout <= 1'b0;
        end else if (cen) begin
          acc  <= sum[W-1:0];
          dout <= sum[W];
        end
      end
    end else begin : g_o2
      // Integrators carry one spare bit above the clamp range
      localparam int IW = W + 3;

      logic signed [IW-1:0]         i1, i2;
      logic signed [SDM_CALC_W-1:0] fb, i1_n, i2_n;

      // Next integrator values, clamped to +-2^(W+1) so a full-scale
      // input can never wrap the loop into the wrong polarity
      always_comb begin
        fb   = dout ? $signed(sdm_fb(W)) : 32'sd0;
        i1_n = sdm_sat(32'(i1) + $signed(32'(xe)) - fb, W + 2);
        i2_n = sdm_sat(32'(i2) + i1_n - fb, W + 2);
      end

      // Integrator and quantiser registers
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          i1   <= '0;
          i2   <= '0;
          dout <= 1'b0;
        end else if (cen) begin
          i1   <= IW'(i1_n);
          i2   <= IW'(i2_n);
          dout <= ~i2_n[SDM_CALC_W-1];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/jtframe_sdm_dac.sv
// Multi-channel sigma-delta audio DAC. Latches CH PCM samples on snd_stb,
// converts them to offset binary, applies mute and drives one PDM bit per
// channel. MONO fans channel 0 out to every pin.
module jtframe_sdm_dac
  import jtframe_sdm_dac_pkg::*;
#(
  parameter int CH         = 2,
  parameter int W          = 16,
  parameter int SIGNED_SND = 1,
  parameter int ORDER      = 1,
  parameter int MONO       = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [CH*W-1:0] snd,
  input  logic          snd_stb,
  input  logic          mute,
  output logic [CH-1:0] dac_out,
  output logic          busy
);

  localparam logic [W-1:0] MID = W'(sdm_mid(W));

  logic [CH-1:0][W-1:0] x_reg;
  logic [CH-1:0][W-1:0] xe;
  logic [CH-1:0]        mod_bit;

  // Sample latch, independent of cen; a latch coinciding with a cen step
  // only becomes visible to the modulators on the following cen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= '0;
    end else if (snd_stb) begin
      for (int n = 0; n < CH; n++)
        x_reg[n] <= W'(sdm_offset_bin(32'(snd[n*W +: W]), W, SIGNED_SND != 0));
    end
  end

  // busy covers the gap between a latch and the first cen that uses it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          busy <= 1'b0;
    else if (snd_stb) busy <= 1'b1;
    else if (cen)     busy <= 1'b0;
  end

  generate
    for (genvar n = 0; n < CH; n++) begin : g_ch
      // In mono builds only channel 0 runs; the rest sit in reset
      localparam bit HOLD = (MONO != 0) && (n != 0);

      // Mute swaps in mid-scale without touching integrator state
      assign xe[n] = mute ? MID : x_reg[n];

      jtframe_sdm_ch #(
        .W     (W),
        .ORDER (ORDER)
      ) u_ch (
        .clk  (clk),
        .rst  (rst | HOLD),
        .cen  (cen),
        .xe   (xe[n]),
        .dout (mod_bit[n])
      );

      assign dac_out[n] = (MONO != 0) ? mod_bit[0] : mod_bit[n];
    end
  endgenerate

endmodule

// File: doc/jtframe_sdm_dac.md
Name: jtframe_sdm_dac

Overview:
- Parametrised multi-channel sigma-delta audio DAC for the MiST-family base modules.
- Replaces the fixed two-instance 1-bit DAC arrangement.
- Takes CH channels of W-bit PCM (signed or unsigned), latches them on a sample strobe, and drives one 1-bit PDM pin per channel.
- Modulator order is selectable; supports clock-enable decimation, mute and mono fan-out.

Parameters:
- CH, 2: number of audio channels (1..8).
- W, 16: PCM sample width (8..24).
- SIGNED_SND, 1: 1 = two's-complement input, 0 = offset-binary input.
- ORDER, 1: modulator order (1 or 2).
- MONO, 0: 1 = every dac_out bit driven by the channel-0 modulator; other modulators held in reset.

Ports:
- clk, in, 1: DAC clock.
- rst, in, 1: asynchronous active-high reset.
- cen, in, 1: modulator clock enable; state advances only when 1.
- snd, in, CH*W: packed samples, channel n at [n*W+W-1 : n*W].
- snd_stb, in, 1: single-cycle pulse; latches all channels of snd.
- mute, in, 1: forces mid-scale into every modulator.
- dac_out, out, CH: PDM outputs, bit n = channel n.
- busy, out, 1: high for the cycle after a latch, until the first cen that consumes the new sample.

Behaviour:
- Reset (async, rst=1): all sample registers = 0, all integrators/accumulators = 0, dac_out = 0, busy = 0. Takes effect immediately mid-operation. Modulation resumes from zero state on the first cen after rst falls.
- Input conversion: x = {snd_n[W-1]^SIGNED_SND, snd_n[W-2:0]}, unsigned in [0, 2^W-1]. Signed -2^(W-1) maps to 0; signed 0 maps to 2^(W-1).
- Latching: on a clk edge with snd_stb=1, x_reg[n] <= converted snd_n. This does not depend on cen. busy <= 1. busy clears on the first edge where cen=1 and snd_stb=0.
- Simultaneous snd_stb and cen: the modulator step uses the old x_reg; the new value takes effect on the next cen. busy stays 1.
- Effective input: xe = mute ? 2^(W-1) : x_reg.
- ORDER=1:
  - W+1-bit sum s = acc + xe; acc <= s[W-1:0]; dac_out[n] <= s[W].
  - Ones density is exactly xe/2^W.
  - Output registered; one cen of latency from xe to first affected bit.
- ORDER=2:
  - Signed integrators i1, i2, width W+3.
  - fb = dac_out[n] ? 2^W : 0.
  - i1' = i1 + xe - fb; i2' = i2 + i1' - fb.
  - Each is saturated to [-2^(W+1), 2^(W+1)-1] before being registered.
  - dac_out[n] <= (i2' >= 0).
  - Saturation keeps a full-scale input from overflowing; no wrap-around is permitted.
- MONO=1: dac_out = {CH{mod0}}; channels 1..CH-1 are not evaluated.
- cen=0: every state register and dac_out hold.
- mute is combinational into xe. Toggling it does not disturb integrator state, so there is no reset click.

Decomposition:
- Shared jtframe package holds:
  - the offset-binary conversion function;
  - the saturation function (value, width);
  - constants MID = 2^(W-1) and FB = 2^W, expressed as functions of W.
- One sub-module, jtframe_sdm_ch: a single-channel modulator with ORDER parameter, inputs clk/rst/cen/xe, output bit.
- Top level does latching, mute, mono fan-out and busy, and generates CH instances of jtframe_sdm_ch.

Test Plan:
1. W=16, SIGNED_SND=0, ORDER=1, cen=1, snd=0x8000 strobed once -> dac_out[0] = 0,1,0,1… starting the second cycle after the strobe; exactly 50% over 1024 cycles.
2. SIGNED_SND=1, snd ch0=0x8000 (-32768), ch1=0x7FFF -> ch0 constant 0; ch1 exactly 65535 ones per 65536 cen cycles.
3. ORDER=2, input 0x4000 unsigned, 65536 cycles -> ones count 16384 ±2. Input 0xFFFF -> integrators never exceed 2^17-1 and no sign flip (saturation assertion); ones count ≥ 65530.
4. cen pulsed 1-in-4 with snd_stb on the same cycle as a cen -> modulator uses the old sample for that step; busy high until the next cen; dac_out changes only on cen edges.
5. mute=1 while snd=0xFFFF -> density 50% (±1 over 1024). Release mute -> density returns toward 100% with no integrator reset (i1 continuous).
6. rst asserted mid-stream between clk edges -> dac_out and busy 0 immediately. After release with snd=0x8000 re-strobed, sequence matches scenario 1 from the first cen; MONO=1 build shows all CH bits identical.
